// File: rtl/instr_fetch.sv
// Instruction-fetch stage: issues in-order word requests, buffers returned words with
// their PCs in a small queue, presents the head to decode and drops wrong-path responses.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        InstrValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);

    localparam int unsigned PW        = $clog2(DEPTH);
    localparam int unsigned CW        = PW + 1;
    localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic [31:0]   fpc_q, fpc_d;
    logic [PW-1:0] head_q, head_d;
    logic [CW-1:0] alloc_q, alloc_d;
    logic [CW-1:0] nfill_q, nfill_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic [CW:0]   occ;
    logic          fire;
    logic          fill;
    logic          rsp_drop;
    logic          deq;
    logic [PW-1:0] tail_idx;
    logic [PW-1:0] fill_idx;

    // Entries fill strictly in request order, so the filled entries are always the
    // oldest nfill_q ones and the next one to fill sits at head + nfill_q.
    always_comb begin
        occ            = {1'b0, alloc_q} + {1'b0, drop_q};
        imem_req_valid = !reset && !PCSrcE && (occ < DEPTH_OCC);
        imem_req_addr  = fpc_q;
        fire           = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (drop_q != '0);
        fill           = imem_rsp_valid && (drop_q == '0) && (nfill_q < alloc_q);
        InstrValidD    = !reset && (nfill_q != '0);
        deq            = InstrValidD && !StallD && !PCSrcE;
        tail_idx       = head_q + PW'(alloc_q);
        fill_idx       = head_q + PW'(nfill_q);
    end

    // Head entry presented to decode; NOP bubble when nothing is ready.
    always_comb begin
        InstrD = NOP;
        PCD    = '0;
        if (InstrValidD) begin
            InstrD = data_q[head_q];
            PCD    = pc_q[head_q];
        end
        PCPlus4D = PCD + 32'd4;
    end

    always_comb begin
        fpc_d   = fpc_q;
        head_d  = head_q;
        alloc_d = alloc_q;
        nfill_d = nfill_q;
        drop_d  = drop_q - CW'(rsp_drop);
        if (PCSrcE) begin
            // In-flight requests not answered this cycle become wrong-path drops.
            fpc_d   = PCTargetE & 32'hFFFF_FFFC;
            alloc_d = '0;
            nfill_d = '0;
            drop_d  = drop_d + (alloc_q - nfill_q - CW'(fill));
        end else begin
            if (fire) begin
                fpc_d = fpc_q + 32'd4;
            end
            head_d  = head_q + PW'(deq);
            alloc_d = alloc_q + CW'(fire) - CW'(deq);
            nfill_d = nfill_q + CW'(fill) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q   <= RESET_PC;
            head_q  <= '0;
            alloc_q <= '0;
            nfill_q <= '0;
            drop_q  <= '0;
        end else begin
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            alloc_q <= alloc_d;
            nfill_q <= nfill_d;
            drop_q  <= drop_d;
        end
    end

    // Payload storage needs no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (fire) begin
            pc_q[tail_idx] <= fpc_q;
        end
        if (fill) begin
            data_q[fill_idx] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed opening sequence with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_instr_fetch;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          NDIR  = 34;
    localparam int          NCYC  = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        InstrValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .StallD         (StallD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrValidD    (InstrValidD),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          filled;
    } ent_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    ent_t        mq[$];
    rsp_t        pend[$];
    int          drop_m;
    logic [31:0] fpc_m;
    int          last_due;
    int          cyc;
    int          tests;
    int          fails;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Check this cycle's outputs against the model, then advance model and memory.
    task automatic step(input int lat);
        logic        exp_rv;
        logic        exp_iv;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        bit          done;
        int          unf;
        int          due;
        rsp_t        r;
        ent_t        e;

        exp_rv    = !reset && !PCSrcE && (mq.size() + drop_m < DEPTH);
        exp_iv    = !reset && (mq.size() > 0) && mq[0].filled;
        exp_pc    = exp_iv ? mq[0].pc : 32'h0;
        exp_instr = exp_iv ? mq[0].data : NOP;

        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, fpc_m);
        chk("InstrValidD", 32'(InstrValidD), 32'(exp_iv));
        chk("InstrD", InstrD, exp_instr);
        chk("PCD", PCD, exp_pc);
        chk("PCPlus4D", PCPlus4D, exp_pc + 32'd4);
        if (InstrValidD) chk("InstrD_vs_mem", InstrD, memf(PCD));

        // Hand-derived expectations for the directed opening sequence
        if (cyc == 1) begin
            chk("lit_rst_req_valid", 32'(imem_req_valid), 32'h0);
            chk("lit_rst_valid", 32'(InstrValidD), 32'h0);
            chk("lit_rst_instr", InstrD, 32'h0000_0013);
            chk("lit_rst_pcplus4", PCPlus4D, 32'h4);
        end
        if (cyc == 2) chk("lit_first_addr", imem_req_addr, 32'h0000_0100);
        if (cyc == 4) begin
            chk("lit_first_valid", 32'(InstrValidD), 32'h1);
            chk("lit_first_pcd", PCD, 32'h0000_0100);
            chk("lit_first_pcp4", PCPlus4D, 32'h0000_0104);
        end
        if (cyc == 5) chk("lit_second_pcd", PCD, 32'h0000_0104);
        if (cyc == 10) begin
            chk("lit_held_valid", 32'(imem_req_valid), 32'h1);
            chk("lit_held_addr", imem_req_addr, 32'h0000_0118);
        end
        if (cyc == 18) begin
            chk("lit_full_req_valid", 32'(imem_req_valid), 32'h0);
            chk("lit_stall_pcd", PCD, 32'h0000_011C);
        end
        if (cyc == 21) chk("lit_resume_pcd", PCD, 32'h0000_0120);
        if (cyc == 22) chk("lit_redir_req_valid", 32'(imem_req_valid), 32'h0);
        if (cyc == 23) begin
            chk("lit_redir_flush", 32'(InstrValidD), 32'h0);
            chk("lit_redir_addr", imem_req_addr, 32'h0000_2000);
        end
        if (cyc == 25) chk("lit_redir_pcd", PCD, 32'h0000_2000);
        if (cyc == 31) begin
            chk("lit_rerst_valid", 32'(InstrValidD), 32'h0);
            chk("lit_rerst_pcd", PCD, 32'h0);
            chk("lit_rerst_addr", imem_req_addr, 32'h0000_0100);
        end

        if (reset) begin
            mq.delete();
            pend.delete();
            drop_m   = 0;
            fpc_m    = RPC;
            last_due = cyc;
            return;
        end

        // Memory: in-order responses, at most one per cycle, latency >= 1
        if (imem_rsp_valid) void'(pend.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            r.due    = due;
            r.data   = memf(imem_req_addr);
            pend.push_back(r);
            last_due = due;
        end

        if (imem_rsp_valid) begin
            if (drop_m > 0) begin
                drop_m--;
            end else begin
                done = 1'b0;
                for (int i = 0; i < mq.size(); i++) begin
                    if (!done && !mq[i].filled) begin
                        mq[i].filled = 1'b1;
                        mq[i].data   = imem_rsp_data;
                        done         = 1'b1;
                    end
                end
            end
        end

        if (PCSrcE) begin
            unf = 0;
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].filled) unf++;
            end
            drop_m += unf;
            mq.delete();
            fpc_m = PCTargetE & 32'hFFFF_FFFC;
        end else begin
            if (exp_iv && !StallD) void'(mq.pop_front());
            if (exp_rv && imem_req_ready) begin
                e.pc     = fpc_m;
                e.data   = 32'h0;
                e.filled = 1'b0;
                mq.push_back(e);
                fpc_m = fpc_m + 32'd4;
            end
        end
    endtask

    initial begin
        int lat;
        reset          = 1'b1;
        StallD         = 1'b0;
        PCSrcE         = 1'b0;
        PCTargetE      = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        fpc_m          = RPC;
        drop_m         = 0;
        last_due       = -1;
        tests          = 0;
        fails          = 0;
        cyc            = 0;

        for (int c = 0; c < NDIR + NCYC; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            if (c < NDIR) begin
                reset          = (c < 2) || (c == 30);
                imem_req_ready = !(c >= 8 && c <= 10);
                StallD         = (c >= 14 && c <= 19);
                PCSrcE         = (c == 22);
                PCTargetE      = 32'h0000_2003;
                lat            = 1;
            end else begin
                reset          = ($urandom_range(0, 199) == 0);
                imem_req_ready = ($urandom_range(0, 9) < 7);
                StallD         = ($urandom_range(0, 9) < 3);
                PCSrcE         = ($urandom_range(0, 19) == 0);
                PCTargetE      = $urandom;
                lat            = int'($urandom_range(1, 4));
            end
            imem_rsp_valid = (pend.size() > 0) && (pend[0].due == c);
            imem_rsp_data  = imem_rsp_valid ? pend[0].data : $urandom;
            #1;
            step(lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
